// File: rtl/vga_display_timing_param.sv
// Parameterised VGA raster timing with STOP/RUN/DRAIN control and a
// latency-matched registered pixel/sync output stage.
module vga_display_timing_param #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COLOR_W   = 4,
    parameter int PIPE_LAT  = 1
) (
    input  logic               iCLOCK,
    input  logic               iRESET,
    input  logic               iRESET_SYNC,
    input  logic               iENABLE,
    output logic               oDATA_REQ,
    output logic [11:0]        oH_COUNT,
    output logic [11:0]        oV_COUNT,
    output logic               oLINE_START,
    output logic               oFRAME_START,
    input  logic               iPIXEL_VALID,
    input  logic [COLOR_W-1:0] iPIXEL_R,
    input  logic [COLOR_W-1:0] iPIXEL_G,
    input  logic [COLOR_W-1:0] iPIXEL_B,
    output logic               oDISP_HSYNC,
    output logic               oDISP_VSYNC,
    output logic               onDISP_BLANK,
    output logic [COLOR_W-1:0] oDISP_R,
    output logic [COLOR_W-1:0] oDISP_G,
    output logic [COLOR_W-1:0] oDISP_B,
    output logic               oUNDERFLOW,
    input  logic               iUNDERFLOW_CLR,
    output logic               oRUNNING
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic req;
        logic hs;
        logic vs;
    } raw_t;

    state_t      state, state_nxt;
    logic [11:0] h_cnt, v_cnt;
    logic        running, h_end, frame_end, uf_set;
    raw_t        raw, dly_out;
    raw_t        dly [PIPE_LAT];

    assign running   = (state != ST_STOP);
    assign h_end     = (h_cnt == H_LAST);
    assign frame_end = h_end && (v_cnt == V_LAST);

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET)
            state <= ST_STOP;
        else if (iRESET_SYNC)
            state <= ST_STOP;
        else
            state <= state_nxt;
    end

    // Draining keeps counting so only whole frames ever reach the pins.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_STOP:  if (iENABLE) state_nxt = ST_RUN;
            ST_RUN:   if (!iENABLE) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (iENABLE)
                    state_nxt = ST_RUN;
                else if (frame_end)
                    state_nxt = ST_STOP;
            end
            default:  state_nxt = ST_STOP;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (iRESET_SYNC || !running) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    always_comb begin
        raw.req = running && (int'(h_cnt) < H_ACTIVE)
                  && (int'(v_cnt) < V_ACTIVE);
        raw.hs  = running && (int'(h_cnt) >= HS_BEG)
                  && (int'(h_cnt) < HS_END);
        raw.vs  = running && (int'(v_cnt) >= VS_BEG)
                  && (int'(v_cnt) < VS_END);
    end

    assign oDATA_REQ    = raw.req;
    assign oH_COUNT     = h_cnt;
    assign oV_COUNT     = v_cnt;
    assign oLINE_START  = running && (h_cnt == 12'd0);
    assign oFRAME_START = oLINE_START && (v_cnt == 12'd0);
    assign oRUNNING     = running;

    // Matches the external pixel source latency before the pin register.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
        end else if (iRESET_SYNC) begin
            for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= raw;
            for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign dly_out = dly[PIPE_LAT-1];
    assign uf_set  = dly_out.req && !iPIXEL_VALID;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            oDISP_HSYNC  <= !HSYNC_POL;
            oDISP_VSYNC  <= !VSYNC_POL;
            onDISP_BLANK <= 1'b0;
            oDISP_R      <= '0;
            oDISP_G      <= '0;
            oDISP_B      <= '0;
            oUNDERFLOW   <= 1'b0;
        end else if (iRESET_SYNC) begin
            oDISP_HSYNC  <= !HSYNC_POL;
            oDISP_VSYNC  <= !VSYNC_POL;
            onDISP_BLANK <= 1'b0;
            oDISP_R      <= '0;
            oDISP_G      <= '0;
            oDISP_B      <= '0;
            oUNDERFLOW   <= 1'b0;
        end else begin
            oDISP_HSYNC  <= dly_out.hs ? HSYNC_POL : !HSYNC_POL;
            oDISP_VSYNC  <= dly_out.vs ? VSYNC_POL : !VSYNC_POL;
            onDISP_BLANK <= dly_out.req;
            if (dly_out.req && iPIXEL_VALID) begin
                oDISP_R <= iPIXEL_R;
                oDISP_G <= iPIXEL_G;
                oDISP_B <= iPIXEL_B;
            end else begin
                oDISP_R <= '0;
                oDISP_G <= '0;
                oDISP_B <= '0;
            end
            oUNDERFLOW <= uf_set || (oUNDERFLOW && !iUNDERFLOW_CLR);
        end
    end

endmodule
